// File: rtl/l1_lookup_ctrl.sv
// L1 lookup controller: one outstanding lookup, serial way-by-way tag search,
// lru start/done handshake, tag install on miss, single-cycle response pulse.
module l1_lookup_ctrl #(
    parameter int unsigned WAY             = 4,
    parameter int unsigned BLOCK_SIZE_BYTE = 16,
    parameter int unsigned CACHE_SIZE_BYTE = 32768,
    parameter int unsigned ADDR_WIDTH      = 32,
    localparam int unsigned OFFSET    = $clog2(BLOCK_SIZE_BYTE),
    localparam int unsigned SET       = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int unsigned SET_INDEX = $clog2(SET),
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - SET_INDEX - OFFSET,
    localparam int unsigned WW        = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [4:0]            resp_way,
    output logic                  resp_evict,
    output logic                  lru_start,
    output logic                  lru_found,
    output logic                  lru_updated,
    output logic                  lru_replace,
    output logic [SET_INDEX-1:0]  lru_index,
    output logic [4:0]            lru_way_index,
    input  logic                  lru_done,
    input  logic                  lru_block_replace,
    input  logic [4:0]            lru_replace_index,
    output logic                  protocol_err
);

    typedef enum logic [2:0] {
        StQuiesce, StIdle, StSearch, StLruReq, StLruWait, StFill, StResp, StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [WW-1:0]        w_q, w_d;
    logic [SET_INDEX-1:0] idx_q, idx_d;
    logic [TAG_WIDTH-1:0] rtag_q, rtag_d;
    logic                 hit_q, hit_d, empty_q, empty_d, evict_q, evict_d, perr_q, perr_d;
    logic [WW-1:0]        hit_way_q, hit_way_d, empty_way_q, empty_way_d, victim_q, victim_d;
    logic                 fill_en, flag_en;
    logic [WW-1:0]        fill_way;

    logic [WAY-1:0]       valid_q [SET];
    logic [TAG_WIDTH-1:0] tag_q   [SET][WAY];

    logic unused_bits;
    assign unused_bits = ^{lru_replace_index[4:WW], req_addr[OFFSET-1:0]};

    assign fill_way = empty_q ? empty_way_q : victim_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        idx_d       = idx_q;
        rtag_d      = rtag_q;
        hit_d       = hit_q;
        hit_way_d   = hit_way_q;
        empty_d     = empty_q;
        empty_way_d = empty_way_q;
        victim_d    = victim_q;
        evict_d     = evict_q;
        perr_d      = perr_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        lru_start   = 1'b0;
        fill_en     = 1'b0;
        flag_en     = 1'b0;
        case (state_q)
            StQuiesce: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q <= 5'd1) state_d = StIdle;
            end
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d       = req_addr[OFFSET +: SET_INDEX];
                    rtag_d      = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    hit_d       = 1'b0;
                    hit_way_d   = '0;
                    empty_d     = 1'b0;
                    empty_way_d = '0;
                    victim_d    = '0;
                    evict_d     = 1'b0;
                    w_d         = '0;
                    state_d     = StSearch;
                end
            end
            StSearch: begin
                // Full scan every time; first match / first empty way are kept.
                if (valid_q[idx_q][w_q] && (tag_q[idx_q][w_q] == rtag_q) && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_way_d = w_q;
                end
                if (!valid_q[idx_q][w_q] && !empty_q) begin
                    empty_d     = 1'b1;
                    empty_way_d = w_q;
                end
                if (w_q == WW'(WAY - 1)) state_d = StLruReq;
                else w_d = w_q + 1'b1;
            end
            StLruReq: begin
                lru_start = 1'b1;
                flag_en   = 1'b1;
                state_d   = StLruWait;
            end
            StLruWait: begin
                flag_en = 1'b1;
                if (lru_done) begin
                    if (!hit_q && !empty_q) begin
                        evict_d = 1'b1;
                        if (lru_block_replace) begin
                            victim_d = lru_replace_index[WW-1:0];
                        end else begin
                            victim_d = '0;
                            perr_d   = 1'b1;
                        end
                    end
                    state_d = hit_q ? StResp : StFill;
                end
            end
            StFill: begin
                flag_en = 1'b1;
                fill_en = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StDrain;
            end
            StDrain: begin
                if (!lru_done) state_d = StIdle;
            end
            default: state_d = StQuiesce;
        endcase
    end

    assign resp_hit      = resp_valid & hit_q;
    assign resp_way      = resp_valid ? (hit_q ? 5'(hit_way_q) : 5'(fill_way)) : 5'd0;
    assign resp_evict    = resp_valid & evict_q;
    assign lru_found     = flag_en & hit_q;
    assign lru_updated   = flag_en & !hit_q & empty_q;
    assign lru_replace   = flag_en & !hit_q & !empty_q;
    assign lru_way_index = (flag_en && hit_q) ? 5'(hit_way_q) + 5'd1 : 5'd0;
    assign lru_index     = idx_q;
    assign protocol_err  = perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StQuiesce;
            cnt_q       <= 5'(WAY + 3);
            w_q         <= '0;
            idx_q       <= '0;
            rtag_q      <= '0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            empty_q     <= 1'b0;
            empty_way_q <= '0;
            victim_q    <= '0;
            evict_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            idx_q       <= idx_d;
            rtag_q      <= rtag_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
            empty_q     <= empty_d;
            empty_way_q <= empty_way_d;
            victim_q    <= victim_d;
            evict_q     <= evict_d;
            perr_q      <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET; s++) valid_q[s] <= '0;
        end else if (fill_en) begin
            valid_q[idx_q][fill_way] <= 1'b1;
        end
    end

    // Tags need no reset: they are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_en) tag_q[idx_q][fill_way] <= rtag_q;
    end

endmodule

// File: tb/tb_l1_lookup_ctrl.sv
// Scoreboard bench for l1_lookup_ctrl: reference tag model predicts each response,
// a simple lru responder answers lru_start with done five cycles later.
module tb_l1_lookup_ctrl;

    localparam int WAY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready, resp_valid, resp_hit, resp_evict;
    logic [4:0]  resp_way, lru_way_index;
    logic        lru_start, lru_found, lru_updated, lru_replace, protocol_err;
    logic [8:0]  lru_index;
    logic        lru_done = 1'b0;
    logic        lru_block_replace;
    logic [4:0]  lru_replace_index;

    l1_lookup_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_evict        (resp_evict),
        .lru_start         (lru_start),
        .lru_found         (lru_found),
        .lru_updated       (lru_updated),
        .lru_replace       (lru_replace),
        .lru_index         (lru_index),
        .lru_way_index     (lru_way_index),
        .lru_done          (lru_done),
        .lru_block_replace (lru_block_replace),
        .lru_replace_index (lru_replace_index),
        .protocol_err      (protocol_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_resp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // lru responder
    int   lru_cnt = 0;
    int   done_left = 0;
    int   hold = 1;
    logic cfg_br = 1'b1;
    logic [4:0] cfg_victim = 5'd0;
    assign lru_block_replace = cfg_br;
    assign lru_replace_index = cfg_victim;

    always @(posedge clk) begin
        if (lru_start) lru_cnt <= 4;
        else if (lru_cnt != 0) lru_cnt <= lru_cnt - 1;
        if (lru_cnt == 1) begin
            lru_done  <= 1'b1;
            done_left <= hold;
        end else if (lru_done) begin
            if (done_left <= 1) lru_done <= 1'b0;
            else done_left <= done_left - 1;
        end
    end

    // Reference model and scoreboard
    typedef struct {
        logic       hit;
        logic [4:0] way;
        logic       evict;
        int         acc;
        logic [8:0] idx;
    } exp_t;
    exp_t exp_q[$];

    logic [WAY-1:0] m_valid [512];
    logic [18:0]    m_tag   [512][WAY];

    always @(negedge clk) begin
        if (!rst) begin
            if (lru_start) begin
                n_start++;
                if (exp_q.size() == 0) begin
                    check("lru_start_unexpected", 32'd1, 32'd0);
                end else begin
                    check("lru_start_latency", cyc - exp_q[0].acc, WAY);
                    check("lru_found", lru_found, exp_q[0].hit);
                    check("lru_updated", lru_updated, !exp_q[0].hit && !exp_q[0].evict);
                    check("lru_replace", lru_replace, exp_q[0].evict);
                    check("lru_index", lru_index, exp_q[0].idx);
                    if (exp_q[0].hit) check("lru_way_index", lru_way_index, exp_q[0].way + 1);
                end
            end
            if (resp_valid) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_latency", cyc - e.acc, e.hit ? 2 * WAY + 2 : 2 * WAY + 3);
                    check("resp_hit", resp_hit, e.hit);
                    check("resp_way", resp_way, e.way);
                    check("resp_evict", resp_evict, e.evict);
                end
            end
        end
    end

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int s = 0; s < 512; s++) m_valid[s] = '0;
        @(negedge clk);
        check("reset_outputs",
              {resp_valid, lru_start, req_ready, protocol_err, lru_found, lru_updated, lru_replace},
              32'd0);
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("quiesce_cycles", n, WAY + 3);
    endtask

    task automatic issue(input logic [31:0] addr);
        exp_t e;
        logic [8:0]  idx;
        logic [18:0] tg;
        logic        found_empty;
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
        idx = addr[12:4];
        tg  = addr[31:13];
        e.hit = 1'b0; e.way = '0; e.evict = 1'b0; e.idx = idx;
        for (int w = 0; w < WAY; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg && !e.hit) begin
                e.hit = 1'b1;
                e.way = 5'(w);
            end
        if (!e.hit) begin
            found_empty = 1'b0;
            for (int w = 0; w < WAY; w++)
                if (!m_valid[idx][w] && !found_empty) begin
                    found_empty = 1'b1;
                    e.way = 5'(w);
                end
            if (!found_empty) begin
                e.evict = 1'b1;
                e.way   = cfg_br ? cfg_victim : 5'd0;
            end
            m_valid[idx][e.way[1:0]] = 1'b1;
            m_tag[idx][e.way[1:0]]   = tg;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int start, n;
        start = n_resp;
        n = 0;
        while (n_resp == start && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n_resp == start) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input logic [31:0] addr);
        issue(addr);
        wait_resp();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, starts, resps;
        do_reset();

        access(32'h0000_1230);                  // cold miss, way 0
        access(32'h0000_1230);                  // hit way 0
        for (int k = 1; k < 4; k++) access(32'h0000_1230 + k * 32'h2000);
        cfg_victim = 5'd0;
        access(32'h0000_1230 + 4 * 32'h2000);   // set full, victim 0
        cfg_victim = 5'd2;
        access(32'h0000_1230 + 5 * 32'h2000);   // set full, victim 2
        access(32'h0000_1230 + 5 * 32'h2000);   // hit way 2
        check("perr_clear", protocol_err, 1'b0);

        cfg_br = 1'b0;
        cfg_victim = 5'd3;
        access(32'h0000_1230 + 6 * 32'h2000);   // bad lru reply: victim forced to 0
        check("perr_set", protocol_err, 1'b1);
        cfg_br = 1'b1;

        // lru_done held long past the response: no new accept until it drops
        hold = 5;
        starts = n_start;
        issue(32'h0000_1230 + 6 * 32'h2000);
        wait_resp();
        n = 0;
        while (lru_done && n < 20) begin
            check("ready_in_drain", req_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("ready_after_drain", req_ready, 1'b1);
        check("one_lru_start", n_start - starts, 1);
        check("perr_sticky", protocol_err, 1'b1);
        hold = 1;
        repeat (2) @(negedge clk);

        // reset in LRU_WAIT abandons the request
        issue(32'h0000_1230 + 7 * 32'h2000);
        n = 0;
        starts = n_start;
        while (n_start == starts && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        resps = n_resp;
        do_reset();
        repeat (20) @(negedge clk);
        check("no_resp_after_rst", n_resp - resps, 0);
        check("perr_after_rst", protocol_err, 1'b0);
        access(32'h0000_1230);                  // valid bits cleared: miss again

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
